// File: rtl/whack_input_conditioner.sv
// whack_input_conditioner
//   Conditions the raw board buttons and switches for the whack-a-mole game. Each input bit goes through a
//   2-flop synchroniser and its own debounce counter, which produces a clean level and a one-cycle event
//   pulse. After reset the block stays in a PRIME phase while inputs held through reset settle, and emits
//   no pulses during that phase. lock_i masks pulses but not levels.
// Ports
//   clock_i          system clock, rising edge
//   reset_i          asynchronous active-low reset
//   buttons_i        raw push buttons (asynchronous)
//   switches_i       raw slide switches (asynchronous)
//   lock_i           1 = drop all event pulses
//   buttons_o        debounced button levels
//   button_press_o   one-cycle pulse on debounced button 0->1
//   switches_o       debounced switch levels
//   switch_toggle_o  one-cycle pulse on any debounced switch change
//   any_press_o      OR of button_press_o
//   primed_o         1 once the PRIME phase has completed
module whack_input_conditioner #(
  parameter int unsigned NUM_BUTTONS     = 4,
  parameter int unsigned NUM_SWITCHES    = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic [NUM_BUTTONS-1:0]  buttons_i,
  input  logic [NUM_SWITCHES-1:0] switches_i,
  input  logic                    lock_i,
  output logic [NUM_BUTTONS-1:0]  buttons_o,
  output logic [NUM_BUTTONS-1:0]  button_press_o,
  output logic [NUM_SWITCHES-1:0] switches_o,
  output logic [NUM_SWITCHES-1:0] switch_toggle_o,
  output logic                    any_press_o,
  output logic                    primed_o
);

  localparam int unsigned NB = NUM_BUTTONS;
  localparam int unsigned NS = NUM_SWITCHES;
  localparam int unsigned N  = NB + NS;
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PW = $clog2(DEBOUNCE_CYCLES + 3);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRIME_LAST = PW'(DEBOUNCE_CYCLES + 2);

  typedef enum logic {
    S_PRIME = 1'b0,
    S_RUN   = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   prime_cnt_q, prime_cnt_d;
  logic            primed_q, primed_d;
  logic            pulse_en_c;

  logic [N-1:0]    sync1_q, sync2_q;
  logic [N-1:0]    stable_q, stable_d;
  logic [CW-1:0]   cnt_q [N];
  logic [CW-1:0]   cnt_d [N];
  logic [N-1:0]    flip_c;

  logic [NB-1:0]   press_q, press_d;
  logic [NS-1:0]   toggle_q, toggle_d;

  // State, prime counter and primed flag
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= S_PRIME;
      prime_cnt_q <= '0;
      primed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      prime_cnt_q <= prime_cnt_d;
      primed_q    <= primed_d;
    end
  end

  // PRIME counts out DEBOUNCE_CYCLES+3 edges, then RUN until the next reset
  always_comb begin
    state_d     = state_q;
    prime_cnt_d = prime_cnt_q;
    pulse_en_c  = 1'b0;
    case (state_q)
      S_PRIME: begin
        if (prime_cnt_q == PRIME_LAST) begin
          state_d     = S_RUN;
          prime_cnt_d = '0;
        end else begin
          prime_cnt_d = prime_cnt_q + PW'(1);
        end
      end
      S_RUN:   pulse_en_c = ~lock_i;
      default: state_d = S_PRIME;
    endcase
    primed_d = (state_d == S_RUN);
  end

  // Per-bit debounce: count consecutive mismatches, flip on the last one
  always_comb begin
    stable_d = stable_q;
    flip_c   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          flip_c[i]   = 1'b1;
          stable_d[i] = ~stable_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Pulses coincide with the cycle the new level first appears
  always_comb begin
    press_d  = flip_c[NB-1:0] & ~stable_q[NB-1:0] & {NB{pulse_en_c}};
    toggle_d = flip_c[N-1:NB] & {NS{pulse_en_c}};
  end

  // Synchronisers, debounce state and pulse registers
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      press_q  <= '0;
      toggle_q <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= {switches_i, buttons_i};
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      toggle_q <= toggle_d;
      for (int unsigned i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign buttons_o       = stable_q[NB-1:0];
  assign switches_o      = stable_q[N-1:NB];
  assign button_press_o  = press_q;
  assign switch_toggle_o = toggle_q;
  assign any_press_o     = |press_q;
  assign primed_o        = primed_q;

endmodule

// File: tb/tb_whack_input_conditioner.sv
// Bench for whack_input_conditioner with DEBOUNCE_CYCLES=4. Stimulus pushes the expected output snapshot
// and the edge count at which it must appear; the monitor pops one entry whenever any output changes.
module tb_whack_input_conditioner;

  logic        clk;
  logic        reset_i;
  logic [3:0]  buttons_i;
  logic [15:0] switches_i;
  logic        lock_i;
  logic [3:0]  buttons_o;
  logic [3:0]  button_press_o;
  logic [15:0] switches_o;
  logic [15:0] switch_toggle_o;
  logic        any_press_o;
  logic        primed_o;

  typedef struct packed {
    logic        primed;
    logic        any;
    logic [3:0]  btn;
    logic [3:0]  press;
    logic [15:0] sw;
    logic [15:0] tog;
  } snap_t;

  typedef struct packed {
    int unsigned cyc;
    snap_t       s;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc;
  int          checks;
  int          failures;
  logic        mon_en;
  snap_t       prev_s;

  whack_input_conditioner #(
    .NUM_BUTTONS    (4),
    .NUM_SWITCHES   (16),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock_i        (clk),
    .reset_i        (reset_i),
    .buttons_i      (buttons_i),
    .switches_i     (switches_i),
    .lock_i         (lock_i),
    .buttons_o      (buttons_o),
    .button_press_o (button_press_o),
    .switches_o     (switches_o),
    .switch_toggle_o(switch_toggle_o),
    .any_press_o    (any_press_o),
    .primed_o       (primed_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic snap_t cur_snap();
    snap_t s;
    s.primed = primed_o;
    s.any    = any_press_o;
    s.btn    = buttons_o;
    s.press  = button_press_o;
    s.sw     = switches_o;
    s.tog    = switch_toggle_o;
    return s;
  endfunction

  function automatic void push(int unsigned c, logic [3:0] b, logic [3:0] p,
                               logic [15:0] sw, logic [15:0] t, logic pr);
    exp_t e;
    e.cyc      = c;
    e.s.primed = pr;
    e.s.any    = |p;
    e.s.btn    = b;
    e.s.press  = p;
    e.s.sw     = sw;
    e.s.tog    = t;
    exp_q.push_back(e);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    snap_t s;
    s = cur_snap();
    checks++;
    if (s !== '0) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, s, 42'h0);
    end
  endtask

  // Monitor: every output change must match the next expected snapshot at the expected edge
  always @(negedge clk) begin
    if (mon_en) begin
      snap_t s;
      exp_t  e;
      s = cur_snap();
      if (s !== prev_s) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output cyc=%0d got=%h", cyc, s);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.s !== s) begin
            failures++;
            $display("FAIL output_event cyc=%0d got=%h exp_cyc=%0d exp=%h", cyc, s, e.cyc, e.s);
          end
        end
      end
      prev_s = s;
    end
  end

  initial begin
    int unsigned c;
    checks     = 0;
    failures   = 0;
    mon_en     = 1'b0;
    prev_s     = '0;
    reset_i    = 1'b1;
    buttons_i  = '0;
    switches_i = '0;
    lock_i     = 1'b0;

    // Reset with switches held: settle silently, primed one edge later
    #2;
    reset_i    = 1'b0;
    switches_i = 16'h0005;
    #1;
    check_all_zero("reset_state");
    mon_en = 1'b1;
    tick(3);
    reset_i = 1'b1;
    c = cyc;
    push(c + 6, 4'h0, 4'h0, 16'h0005, 16'h0000, 1'b0);
    push(c + 7, 4'h0, 4'h0, 16'h0005, 16'h0000, 1'b1);
    tick(10);

    // Switch falling edge pulses too
    switches_i[0] = 1'b0;
    c = cyc;
    push(c + 6, 4'h0, 4'h0, 16'h0004, 16'h0001, 1'b1);
    push(c + 7, 4'h0, 4'h0, 16'h0004, 16'h0000, 1'b1);
    tick(10);

    // Button press then release (no pulse on release)
    buttons_i[2] = 1'b1;
    c = cyc;
    push(c + 6, 4'h4, 4'h4, 16'h0004, 16'h0000, 1'b1);
    push(c + 7, 4'h4, 4'h0, 16'h0004, 16'h0000, 1'b1);
    tick(10);
    buttons_i[2] = 1'b0;
    c = cyc;
    push(c + 6, 4'h0, 4'h0, 16'h0004, 16'h0000, 1'b1);
    tick(10);

    // Glitch shorter than the debounce window is ignored
    switches_i[9] = 1'b1;
    tick(3);
    switches_i[9] = 1'b0;
    tick(10);

    // Bounce 1,0,1 then hold: one pulse after the final edge
    switches_i[0] = 1'b1;
    tick(2);
    switches_i[0] = 1'b0;
    tick(2);
    switches_i[0] = 1'b1;
    c = cyc;
    push(c + 6, 4'h0, 4'h0, 16'h0005, 16'h0001, 1'b1);
    push(c + 7, 4'h0, 4'h0, 16'h0005, 16'h0000, 1'b1);
    tick(10);

    // Locked change: level follows, pulse dropped, nothing on unlock
    lock_i        = 1'b1;
    switches_i[3] = 1'b1;
    c = cyc;
    push(c + 6, 4'h0, 4'h0, 16'h000D, 16'h0000, 1'b1);
    tick(8);
    lock_i = 1'b0;
    tick(6);

    // Reset mid-debounce clears everything at once; PRIME repeats silently
    buttons_i[1] = 1'b1;
    tick(3);
    reset_i = 1'b0;
    push(cyc, 4'h0, 4'h0, 16'h0000, 16'h0000, 1'b0);
    #1;
    check_all_zero("mid_reset_state");
    tick(2);
    reset_i = 1'b1;
    c = cyc;
    push(c + 6, 4'h2, 4'h0, 16'h000D, 16'h0000, 1'b0);
    push(c + 7, 4'h2, 4'h0, 16'h000D, 16'h0000, 1'b1);
    tick(14);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events got=%0d exp=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
